// File: rtl/gppcu_pkg.sv
// Shared GPPCU host command definitions: opcodes, readback status layout and
// LMEM reader FSM encoding.
package gppcu_pkg;

   localparam int unsigned OP_W = 7;

   localparam logic [OP_W-1:0] OPR_INSTR   = 7'd0;
   localparam logic [OP_W-1:0] OPR_RDL     = 7'd1;
   localparam logic [OP_W-1:0] OPR_WRL     = 7'd2;
   localparam logic [OP_W-1:0] OPR_WRG     = 7'd3;
   localparam logic [OP_W-1:0] OPR_RDBURST = 7'd4;
   localparam logic [OP_W-1:0] OPR_POP     = 7'd5;
   localparam logic [OP_W-1:0] OPR_STATUS  = 7'd6;
   localparam logic [OP_W-1:0] OPR_ABORT   = 7'd7;

   // STATUS word bit positions
   localparam int unsigned STAT_BUSY_BIT  = 31;
   localparam int unsigned STAT_BERR_BIT  = 30;
   localparam int unsigned STAT_UFLOW_BIT = 29;
   localparam int unsigned STAT_CNT_LSB   = 24;
   localparam int unsigned STAT_CNT_W     = 5;
   localparam int unsigned STAT_REM_W     = 16;

   typedef struct packed {
      logic                  busy;
      logic                  burst_err;
      logic                  underflow;
      logic [STAT_CNT_W-1:0] fifo_cnt;
      logic [7:0]            rsvd;
      logic [STAT_REM_W-1:0] remaining;
   } status_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

endpackage

// File: rtl/gppcu_sync_fifo.sv
// Single-clock FIFO with push, pop, flush and occupancy count; head word is
// visible combinationally so a pop can be registered by the consumer.
module gppcu_sync_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 32
) (
   input  logic                     opclk,
   input  logic                     inRST,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             head_c,
   output logic [$clog2(DEPTH):0]   cnt_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push_c, do_pop_c;

   // A push into a full FIFO is accepted only when a pop frees a slot
   always_comb begin
      do_pop_c  = pop_i && (cnt_q != '0);
      do_push_c = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop_c);
      wr_d      = wr_q + AW'(do_push_c);
      rd_d      = rd_q + AW'(do_pop_c);
      cnt_d     = cnt_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge opclk or negedge inRST) begin
      if (!inRST) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge opclk) begin
      if (do_push_c && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   assign head_c = mem_q[rd_q];
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/gppcu_lmem_reader.sv
// Host readback engine: walks a burst of LMEM reads for one thread, buffers
// returned words in a FIFO and serves POP/STATUS/ABORT from the command bus.
module gppcu_lmem_reader
   import gppcu_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ADDR_BW = 10,
   parameter int unsigned RD_LAT  = 2
) (
   input  logic               opclk,
   input  logic               inRST,
   input  logic [6:0]         iWPARAM,
   input  logic [7:0]         iLPARAM,
   input  logic [15:0]        iARG,
   input  logic [31:0]        iDATA,
   output logic [31:0]        oDATA,
   output logic [7:0]         oLMEM_THREAD_SEL,
   output logic [ADDR_BW-1:0] oLMEM_ADDR,
   output logic               oLMEM_RD,
   input  logic [31:0]        iLMEM_RDATA,
   output logic               oBUSY
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned LEN_W = 16;

   rd_state_e          state_q, state_d;
   logic [7:0]         thread_q, thread_d;
   logic [ADDR_BW-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [RD_LAT-1:0]  pipe_q, pipe_d;
   logic               berr_q, berr_d, uflow_q, uflow_d;
   logic               busy_q, busy_d, rd_q, rd_d;
   logic [31:0]        data_q, data_d;

   logic               push_c, pop_c, flush_c, credit_c;
   logic [31:0]        head_c;
   logic [CNT_W-1:0]   fifo_cnt, inflight_c;
   status_t            status_c;
   logic               unused_c;

   assign unused_c = ^{iARG[15:ADDR_BW], iDATA[31:LEN_W]};

   gppcu_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (32)
   ) u_fifo (
      .opclk   (opclk),
      .inRST   (inRST),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .flush_i (flush_c),
      .wdata_i (iLMEM_RDATA),
      .head_c  (head_c),
      .cnt_o   (fifo_cnt)
   );

   // Every read in the pipe already owns a FIFO slot, so the FIFO never overflows
   assign inflight_c = CNT_W'($countones(pipe_q));
   assign credit_c   = ({1'b0, fifo_cnt} + {1'b0, inflight_c}) < (CNT_W + 1)'(DEPTH);

   always_comb begin
      status_c           = '0;
      status_c.busy      = busy_q;
      status_c.burst_err = berr_q;
      status_c.underflow = uflow_q;
      status_c.fifo_cnt  = STAT_CNT_W'(fifo_cnt);
      status_c.remaining = rem_q;
   end

   // Next-state: burst walk first, then the host opcode (ABORT overrides all)
   always_comb begin
      state_d   = state_q;
      thread_d  = thread_q;
      addr_d    = addr_q;
      rd_addr_d = rd_addr_q;
      rem_d     = rem_q;
      berr_d    = berr_q;
      uflow_d   = uflow_q;
      data_d    = data_q;
      rd_d      = 1'b0;
      pipe_d    = pipe_q << 1;
      push_c    = pipe_q[RD_LAT-1];
      pop_c     = 1'b0;
      flush_c   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (iWPARAM == OPR_RDBURST && iDATA[LEN_W-1:0] != '0) begin
               thread_d = iLPARAM;
               addr_d   = iARG[ADDR_BW-1:0];
               rem_d    = iDATA[LEN_W-1:0];
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (credit_c) begin
               rd_d      = 1'b1;
               rd_addr_d = addr_q;
               addr_d    = addr_q + ADDR_BW'(1);
               rem_d     = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (inflight_c == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      pipe_d[0] = rd_d;

      unique case (iWPARAM)
         OPR_RDBURST: begin
            if (state_q != ST_IDLE) berr_d = 1'b1;
         end
         OPR_POP: begin
            if (fifo_cnt != '0) begin
               data_d = head_c;
               pop_c  = 1'b1;
            end else begin
               data_d  = '0;
               uflow_d = 1'b1;
            end
         end
         OPR_STATUS: begin
            data_d  = status_c;
            berr_d  = 1'b0;
            uflow_d = 1'b0;
         end
         OPR_ABORT: begin
            state_d   = ST_IDLE;
            flush_c   = 1'b1;
            push_c    = 1'b0;
            pipe_d    = '0;
            rem_d     = '0;
            rd_d      = 1'b0;
            rd_addr_d = rd_addr_q;
         end
         default: ;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge opclk or negedge inRST) begin
      if (!inRST) begin
         state_q   <= ST_IDLE;
         thread_q  <= '0;
         addr_q    <= '0;
         rd_addr_q <= '0;
         rem_q     <= '0;
         pipe_q    <= '0;
         berr_q    <= 1'b0;
         uflow_q   <= 1'b0;
         busy_q    <= 1'b0;
         rd_q      <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         thread_q  <= thread_d;
         addr_q    <= addr_d;
         rd_addr_q <= rd_addr_d;
         rem_q     <= rem_d;
         pipe_q    <= pipe_d;
         berr_q    <= berr_d;
         uflow_q   <= uflow_d;
         busy_q    <= busy_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
      end
   end

   assign oDATA            = data_q;
   assign oLMEM_THREAD_SEL = thread_q;
   assign oLMEM_ADDR       = rd_addr_q;
   assign oLMEM_RD         = rd_q;
   assign oBUSY            = busy_q;

endmodule
